// File: rtl/run_trace_controller.sv
// Run controller for a single-cycle processor: gates cpu_en for a programmable
// number of cycles (or until halt_req) and captures a circular execution trace.
module run_trace_controller #(
    parameter int DATA_W      = 32,
    parameter int TRACE_DEPTH = 16,
    parameter int CYCLE_W     = 8,
    localparam int AW         = $clog2(TRACE_DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [CYCLE_W-1:0] cycle_limit,
    input  logic               halt_req,
    input  logic [DATA_W-1:0]  pc_in,
    input  logic [DATA_W-1:0]  alu_in,
    input  logic [DATA_W-1:0]  instr_in,
    output logic               cpu_en,
    output logic               busy,
    output logic               done,
    output logic               halted,
    output logic               overflow,
    output logic [CYCLE_W-1:0] cycles_run,
    input  logic               rd_en,
    input  logic [AW-1:0]      rd_addr,
    output logic               rd_valid,
    output logic [DATA_W-1:0]  rd_pc,
    output logic [DATA_W-1:0]  rd_alu,
    output logic [DATA_W-1:0]  rd_instr,
    output logic [1:0]         dbg_state
);

    localparam int CMP_W = (AW > CYCLE_W) ? AW : CYCLE_W;

    // Handshake: start is a level sampled on each edge while IDLE or DONE;
    // rd_en is sampled on each edge and answered by rd_valid one cycle later.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CYCLE_W-1:0] cycles_q, cycles_d;
    logic [CYCLE_W-1:0] limit_q, limit_d;
    logic               overflow_q, overflow_d;
    logic               halted_q, halted_d;
    logic               trace_we;
    logic               limit_hit;

    logic [3*DATA_W-1:0] trace_mem [TRACE_DEPTH];

    logic               rd_valid_q;
    logic [DATA_W-1:0]  rd_pc_q, rd_alu_q, rd_instr_q;
    logic [AW-1:0]      oldest;
    logic [AW-1:0]      rd_phys;
    logic               rd_in_range;
    logic [3*DATA_W-1:0] rd_word;

    assign limit_hit = (cycles_q + CYCLE_W'(1)) == limit_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            cycles_q   <= '0;
            limit_q    <= '0;
            overflow_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            cycles_q   <= cycles_d;
            limit_q    <= limit_d;
            overflow_q <= overflow_d;
            halted_q   <= halted_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        cycles_d   = cycles_q;
        limit_d    = limit_q;
        overflow_d = overflow_q;
        halted_d   = halted_q;
        trace_we   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    cycles_d   = '0;
                    wr_ptr_d   = '0;
                    overflow_d = 1'b0;
                    halted_d   = 1'b0;
                    limit_d    = cycle_limit;
                    state_d    = (cycle_limit == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                trace_we = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
                cycles_d = cycles_q + CYCLE_W'(1);
                // Slot 0 is only revisited once a full lap has been written.
                if (wr_ptr_q == '0 && cycles_q != '0) begin
                    overflow_d = 1'b1;
                end
                if (limit_hit || halt_req) begin
                    state_d  = ST_DONE;
                    halted_d = halt_req && !limit_hit;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (trace_we) begin
            trace_mem[wr_ptr_q] <= {pc_in, alu_in, instr_in};
        end
    end

    // Logical index 0 is the oldest retained entry; once wrapped that is the
    // slot about to be overwritten next.
    assign oldest      = overflow_q ? wr_ptr_q : '0;
    assign rd_phys     = oldest + rd_addr;
    assign rd_in_range = overflow_q || (CMP_W'(rd_addr) < CMP_W'(cycles_q));
    assign rd_word     = trace_mem[rd_phys];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_valid_q <= 1'b0;
            rd_pc_q    <= '0;
            rd_alu_q   <= '0;
            rd_instr_q <= '0;
        end else if (rd_en) begin
            if (rd_in_range) begin
                rd_valid_q <= 1'b1;
                rd_pc_q    <= rd_word[3*DATA_W-1 -: DATA_W];
                rd_alu_q   <= rd_word[2*DATA_W-1 -: DATA_W];
                rd_instr_q <= rd_word[DATA_W-1:0];
            end else begin
                rd_valid_q <= 1'b0;
                rd_pc_q    <= '0;
                rd_alu_q   <= '0;
                rd_instr_q <= '0;
            end
        end else begin
            rd_valid_q <= 1'b0;
        end
    end

    assign cpu_en     = (state_q == ST_RUN);
    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign halted     = halted_q;
    assign overflow   = overflow_q;
    assign cycles_run = cycles_q;
    assign rd_valid   = rd_valid_q;
    assign rd_pc      = rd_pc_q;
    assign rd_alu     = rd_alu_q;
    assign rd_instr   = rd_instr_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_run_trace_controller.sv
// Directed bench for run_trace_controller: reset, basic run, wrap, halt,
// edge cases and restart, with hand-computed expectations.
module tb_run_trace_controller;

    localparam int DATA_W  = 32;
    localparam int DEPTH   = 16;
    localparam int CYCLE_W = 8;
    localparam int AW      = 4;

    logic               clock;
    logic               reset;
    logic               start;
    logic [CYCLE_W-1:0] cycle_limit;
    logic               halt_req;
    logic [DATA_W-1:0]  pc_in, alu_in, instr_in;
    logic               cpu_en, busy, done, halted, overflow;
    logic [CYCLE_W-1:0] cycles_run;
    logic               rd_en;
    logic [AW-1:0]      rd_addr;
    logic               rd_valid;
    logic [DATA_W-1:0]  rd_pc, rd_alu, rd_instr;
    logic [1:0]         dbg_state;

    int checks   = 0;
    int failures = 0;

    // Processor stand-in: step k advances on every enabled cycle.
    logic        pc_clr;
    logic [31:0] k;

    run_trace_controller #(
        .DATA_W(DATA_W), .TRACE_DEPTH(DEPTH), .CYCLE_W(CYCLE_W)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .cycle_limit(cycle_limit),
        .halt_req(halt_req), .pc_in(pc_in), .alu_in(alu_in), .instr_in(instr_in),
        .cpu_en(cpu_en), .busy(busy), .done(done), .halted(halted),
        .overflow(overflow), .cycles_run(cycles_run), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_alu(rd_alu),
        .rd_instr(rd_instr), .dbg_state(dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (pc_clr) k <= 32'd0;
        else if (cpu_en) k <= k + 32'd1;
    end

    always_comb begin
        pc_in    = k << 2;
        alu_in   = k * 32'd3 + 32'd1;
        instr_in = 32'hA000_0000 | k;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input int lim);
        pc_clr      = 1'b1;
        start       = 1'b1;
        cycle_limit = lim[CYCLE_W-1:0];
        tick();
        start  = 1'b0;
        pc_clr = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int en_cnt, output bit timed_out);
        en_cnt    = 0;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (cpu_en) en_cnt++;
            tick();
        end
    endtask

    task automatic do_read(input int a);
        rd_en   = 1'b1;
        rd_addr = a[AW-1:0];
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) tick();
        checks++;
        if (cpu_en !== 1'b0 || done !== 1'b0 || cycles_run !== 8'd0 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_state: cpu_en=%b done=%b cycles=%0d state=%0d want 0 0 0 0",
                     cpu_en, done, cycles_run, dbg_state);
        end
        reset = 1'b1;
        tick();
        do_start(20);
        repeat (17) tick();
        checks++;
        if (busy !== 1'b1 || overflow !== 1'b1 || cycles_run !== 8'd17) begin
            failures++;
            $display("FAIL pre_reset_run: busy=%b ovf=%b cycles=%0d want 1 1 17",
                     busy, overflow, cycles_run);
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if (cpu_en !== 1'b0 || busy !== 1'b0 || cycles_run !== 8'd0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: cpu_en=%b busy=%b cycles=%0d ovf=%b want all 0",
                     cpu_en, busy, cycles_run, overflow);
        end
        #1 reset = 1'b1;
        tick();
        checks++;
        if (dbg_state !== 2'd0 || done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: state=%0d done=%b busy=%b want 0 0 0", dbg_state, done, busy);
        end
    endtask

    task automatic test_basic();
        int n;
        bit to;
        do_start(16);
        wait_done(100, n, to);
        checks++;
        if (to !== 1'b0 || n != 16) begin
            failures++;
            $display("FAIL basic_cpu_en: timeout=%b cycles_high=%0d want 0 16", to, n);
        end
        checks++;
        if (done !== 1'b1 || cycles_run !== 8'd16 || overflow !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL basic_flags: done=%b cycles=%0d ovf=%b halted=%b want 1 16 0 0",
                     done, cycles_run, overflow, halted);
        end
        for (int i = 0; i < 16; i++) begin
            do_read(i);
            checks++;
            if (rd_valid !== 1'b1 || rd_pc !== 32'(4 * i)) begin
                failures++;
                $display("FAIL basic_read[%0d]: valid=%b pc=%0d want 1 %0d", i, rd_valid, rd_pc, 4 * i);
            end
        end
        do_read(5);
        checks++;
        if (rd_alu !== 32'd16 || rd_instr !== 32'hA000_0005) begin
            failures++;
            $display("FAIL basic_fields: alu=%0d instr=%h want 16 a0000005", rd_alu, rd_instr);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_pc !== 32'd20) begin
            failures++;
            $display("FAIL read_hold: valid=%b pc=%0d want 0 20", rd_valid, rd_pc);
        end
    endtask

    task automatic test_wrap();
        int n;
        bit to;
        do_start(20);
        wait_done(100, n, to);
        checks++;
        if (to !== 1'b0 || n != 20 || overflow !== 1'b1 || cycles_run !== 8'd20) begin
            failures++;
            $display("FAIL wrap_flags: timeout=%b high=%0d ovf=%b cycles=%0d want 0 20 1 20",
                     to, n, overflow, cycles_run);
        end
        do_read(0);
        checks++;
        if (rd_valid !== 1'b1 || rd_pc !== 32'd16) begin
            failures++;
            $display("FAIL wrap_oldest: valid=%b pc=%0d want 1 16", rd_valid, rd_pc);
        end
        do_read(15);
        checks++;
        if (rd_valid !== 1'b1 || rd_pc !== 32'd76) begin
            failures++;
            $display("FAIL wrap_newest: valid=%b pc=%0d want 1 76", rd_valid, rd_pc);
        end
        do_read(12);
        checks++;
        if (rd_valid !== 1'b1 || rd_pc !== 32'd64) begin
            failures++;
            $display("FAIL wrap_mid: valid=%b pc=%0d want 1 64", rd_valid, rd_pc);
        end
    endtask

    task automatic test_halt();
        do_start(10);
        repeat (3) tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        checks++;
        if (done !== 1'b1 || halted !== 1'b1 || cycles_run !== 8'd4 || cpu_en !== 1'b0) begin
            failures++;
            $display("FAIL halt_flags: done=%b halted=%b cycles=%0d cpu_en=%b want 1 1 4 0",
                     done, halted, cycles_run, cpu_en);
        end
        do_read(3);
        checks++;
        if (rd_valid !== 1'b1 || rd_pc !== 32'd12) begin
            failures++;
            $display("FAIL halt_last: valid=%b pc=%0d want 1 12", rd_valid, rd_pc);
        end
        do_read(4);
        checks++;
        if (rd_valid !== 1'b0 || rd_pc !== 32'd0) begin
            failures++;
            $display("FAIL halt_beyond: valid=%b pc=%0d want 0 0", rd_valid, rd_pc);
        end
    endtask

    task automatic test_edges();
        int n;
        bit to;
        do_start(0);
        checks++;
        if (done !== 1'b1 || cpu_en !== 1'b0 || cycles_run !== 8'd0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL limit_zero: done=%b cpu_en=%b cycles=%0d halted=%b want 1 0 0 0",
                     done, cpu_en, cycles_run, halted);
        end
        tick();
        checks++;
        if (done !== 1'b1 || cpu_en !== 1'b0) begin
            failures++;
            $display("FAIL limit_zero_hold: done=%b cpu_en=%b want 1 0", done, cpu_en);
        end
        do_start(5);
        tick();
        start       = 1'b1;
        cycle_limit = 8'd2;
        tick();
        start = 1'b0;
        wait_done(100, n, to);
        checks++;
        if (to !== 1'b0 || n != 3 || cycles_run !== 8'd5) begin
            failures++;
            $display("FAIL start_in_run: timeout=%b remaining_high=%0d cycles=%0d want 0 3 5",
                     to, n, cycles_run);
        end
        do_start(3);
        repeat (2) tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        checks++;
        if (done !== 1'b1 || halted !== 1'b0 || cycles_run !== 8'd3) begin
            failures++;
            $display("FAIL halt_on_limit: done=%b halted=%b cycles=%0d want 1 0 3",
                     done, halted, cycles_run);
        end
    endtask

    task automatic test_restart();
        int n;
        bit to;
        do_start(20);
        wait_done(100, n, to);
        halt_req = 1'b0;
        do_start(3);
        checks++;
        if (busy !== 1'b1 || cycles_run !== 8'd0 || overflow !== 1'b0 || halted !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL restart_clear: busy=%b cycles=%0d ovf=%b halted=%b done=%b want 1 0 0 0 0",
                     busy, cycles_run, overflow, halted, done);
        end
        wait_done(100, n, to);
        checks++;
        if (to !== 1'b0 || n != 3 || cycles_run !== 8'd3) begin
            failures++;
            $display("FAIL restart_run: timeout=%b high=%0d cycles=%0d want 0 3 3", to, n, cycles_run);
        end
        for (int i = 0; i < 3; i++) begin
            do_read(i);
            checks++;
            if (rd_valid !== 1'b1 || rd_pc !== 32'(4 * i)) begin
                failures++;
                $display("FAIL restart_read[%0d]: valid=%b pc=%0d want 1 %0d", i, rd_valid, rd_pc, 4 * i);
            end
        end
        do_read(3);
        checks++;
        if (rd_valid !== 1'b0 || rd_pc !== 32'd0) begin
            failures++;
            $display("FAIL restart_beyond: valid=%b pc=%0d want 0 0", rd_valid, rd_pc);
        end
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        cycle_limit = '0;
        halt_req    = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = '0;
        pc_clr      = 1'b1;
        test_reset();
        test_basic();
        test_wrap();
        test_halt();
        test_edges();
        test_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
